// File: rtl/multi_drop_arbiter.sv
// multi_drop_arbiter: round-robin arbiter driving one shared byte bus and one of three destination enables per transfer
module multi_drop_arbiter #(
  parameter int NREQ     = 4,
  parameter int XFER_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_dest,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        bus,
  output logic              ena,
  output logic              enb,
  output logic              enc,
  output logic              busy,
  output logic              err
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t          state, nstate;
  logic [3:0]      cnt, ncnt;
  logic [IW-1:0]   last, sel, c, nwin;
  logic [7:0]      dat, ndat, bus_d;
  logic [1:0]      dst, ndst;
  logic [NREQ-1:0] gnt_d;
  logic            found, take, fin, ena_d, enb_d, enc_d, err_d;
  always_comb begin
    found = 1'b0;
    sel   = last;
    c     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c = IW'((int'(last) + k) % NREQ);
      if (!found && req[c]) begin
        found = 1'b1;
        sel   = c;
      end
    end
    take = (state == IDLE) && found;
    nwin = take ? sel : last;
    ndat = take ? req_data[8*sel +: 8] : dat;
    ndst = take ? req_dest[2*sel +: 2] : dst;
  end
  always_comb begin
    nstate = (state == IDLE) ? (found ? XFER : IDLE) :
             (state == XFER) ? ((cnt == 4'd0) ? GAP : XFER) : IDLE;
    ncnt   = take ? 4'(XFER_CYC - 1) :
             ((state == XFER) && (cnt != 4'd0)) ? cnt - 4'd1 : cnt;
  end
  // outputs are computed one edge early so every port comes straight from a flop
  always_comb begin
    fin   = (nstate == XFER) && (ncnt == 4'd0);
    bus_d = (nstate == XFER) ? ndat : 8'h00;
    ena_d = (nstate == XFER) && (ndst == 2'd0);
    enb_d = (nstate == XFER) && (ndst == 2'd1);
    enc_d = (nstate == XFER) && (ndst == 2'd2);
    gnt_d = fin ? (NREQ'(1) << nwin) : '0;
    err_d = fin && (ndst == 2'd3);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      last  <= IW'(NREQ - 1);
      dat   <= 8'h00;
      dst   <= 2'd0;
      gnt   <= '0;
      bus   <= 8'h00;
      ena   <= 1'b0;
      enb   <= 1'b0;
      enc   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      last  <= nwin;
      dat   <= ndat;
      dst   <= ndst;
      gnt   <= gnt_d;
      bus   <= bus_d;
      ena   <= ena_d;
      enb   <= enb_d;
      enc   <= enc_d;
      busy  <= (nstate != IDLE);
      err   <= err_d;
    end
  end
endmodule

// File: tb/tb_multi_drop_arbiter.sv
// tb_multi_drop_arbiter: directed checks of three arbiter instances (XFER_CYC 1, 3, 4) sharing one stimulus
module tb_multi_drop_arbiter;
  logic        clk, rst_n;
  logic [3:0]  req;
  logic [7:0]  req_dest;
  logic [31:0] req_data;
  logic [3:0]  gnt1, gnt3, gnt4;
  logic [7:0]  bus1, bus3, bus4;
  logic        ena1, enb1, enc1, busy1, err1;
  logic        ena3, enb3, enc3, busy3, err3;
  logic        ena4, enb4, enc4, busy4, err4;
  int          total = 0, passed = 0, failed = 0;
  int          order [5] = '{0, 1, 2, 3, 0};
  logic [2:0]  ens   [5] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b100};

  multi_drop_arbiter #(.NREQ(4), .XFER_CYC(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dest(req_dest), .req_data(req_data),
    .gnt(gnt1), .bus(bus1), .ena(ena1), .enb(enb1), .enc(enc1), .busy(busy1), .err(err1));
  multi_drop_arbiter #(.NREQ(4), .XFER_CYC(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dest(req_dest), .req_data(req_data),
    .gnt(gnt3), .bus(bus3), .ena(ena3), .enb(enb3), .enc(enc3), .busy(busy3), .err(err3));
  multi_drop_arbiter #(.NREQ(4), .XFER_CYC(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dest(req_dest), .req_data(req_data),
    .gnt(gnt4), .bus(bus4), .ena(ena4), .enb(enb4), .enc(enc4), .busy(busy4), .err(err4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_dest = '0; req_data = '0;
    #1;
    chk("rst_gnt", gnt1, 0);
    chk("rst_bus", bus1, 0);
    chk("rst_en", {ena1, enb1, enc1}, 0);
    chk("rst_busy_err", {busy1, err1}, 0);
    tick();
    rst_n = 1'b1;
    // single request, one-cycle transfer
    req = 4'b0100; req_dest = 8'b00_01_00_00; req_data = 32'h00A50000;
    tick();
    chk("t1_bus", bus1, 8'hA5);
    chk("t1_en", {ena1, enb1, enc1}, 3'b010);
    chk("t1_gnt", gnt1, 4'b0100);
    chk("t1_busy", busy1, 1);
    req = 4'b0000;
    tick();
    chk("t1_gap_bus", bus1, 0);
    chk("t1_gap_en", {ena1, enb1, enc1}, 0);
    chk("t1_gap_gnt_busy", {gnt1, busy1}, 5'b00001);
    tick();
    chk("t1_idle_busy", busy1, 0);
    // round-robin with all requesters held from reset
    req = 4'b1111; req_dest = 8'b00_10_01_00; req_data = 32'h13121110;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr%0d_gnt", i), gnt1, 32'(4'b0001 << order[i]));
      chk($sformatf("rr%0d_en", i), {ena1, enb1, enc1}, ens[i]);
      chk($sformatf("rr%0d_bus", i), bus1, 32'h10 + order[i]);
      tick();
      chk($sformatf("rr%0d_gap", i), {gnt1, bus1}, 0);
      tick();
    end
    // illegal destination
    req = 4'b0000;
    do_reset();
    req = 4'b0001; req_dest = 8'b00_00_00_11; req_data = 32'h0000003C;
    tick();
    chk("ill_bus", bus1, 8'h3C);
    chk("ill_en", {ena1, enb1, enc1}, 0);
    chk("ill_gnt_err", {gnt1, err1}, 5'b00011);
    req = 4'b0000;
    tick();
    chk("ill_after", {gnt1, err1}, 0);
    // three-cycle hold, data changes after selection
    do_reset();
    req = 4'b0010; req_dest = 8'b00_00_10_00; req_data = 32'h00003600;
    tick();
    chk("h1", {bus3, ena3, enb3, enc3, gnt3}, {8'h36, 3'b001, 4'b0000});
    req_data = 32'h0000FF00;
    tick();
    chk("h2", {bus3, ena3, enb3, enc3, gnt3}, {8'h36, 3'b001, 4'b0000});
    tick();
    chk("h3", {bus3, ena3, enb3, enc3, gnt3}, {8'h36, 3'b001, 4'b0010});
    req = 4'b0000;
    tick();
    chk("h_gap", {bus3, ena3, enb3, enc3, gnt3}, 0);
    // asynchronous reset in the second cycle of a four-cycle transfer
    do_reset();
    req = 4'b0001; req_dest = 8'b00_00_00_00; req_data = 32'h00000055;
    tick();
    tick();
    chk("rm_pre", {bus4, ena4, busy4}, {8'h55, 2'b11});
    rst_n = 1'b0;
    #1;
    chk("rm_async", {bus4, ena4, enb4, enc4, gnt4, busy4, err4}, 0);
    req = 4'b1010; req_dest = 8'b00_00_01_00; req_data = 32'h00007700;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rm_first", {bus4, ena4, enb4, enc4, gnt4}, {8'h77, 3'b010, 4'b0000});
    tick(); tick(); tick();
    chk("rm_gnt", gnt4, 4'b0010);
    // late arrival beats a still-pending requester 0
    req = 4'b0000;
    do_reset();
    req = 4'b0001; req_dest = 8'b01_00_00_00; req_data = 32'hD30000A0;
    tick();
    chk("la_g0", {gnt1, bus1}, {4'b0001, 8'hA0});
    req = 4'b1001;
    tick();
    tick();
    tick();
    chk("la_g3", {gnt1, bus1, ena1, enb1, enc1}, {4'b1000, 8'hD3, 3'b010});
    req = 4'b0001;
    tick(); tick(); tick();
    chk("la_g0b", {gnt1, bus1}, {4'b0001, 8'hA0});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
